// File: rtl/bnn_mlp_pipe.sv
// Two-layer XNOR-popcount binary MLP with chunk-serial weight/threshold loader
// and a two-stage valid/ready inference pipeline reporting an argmax class.
module bnn_mlp_pipe #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned N_HID  = 8,
  parameter int unsigned N_OUT  = 4,
  parameter int unsigned CHUNK  = 4,
  parameter int unsigned THR_L1 = 6,
  parameter int unsigned THR_L2 = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ena,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [CHUNK-1:0]           load_data,
  output logic                       load_busy,
  output logic                       load_done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_data,
  output logic [N_HID-1:0]           hid_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT-1:0]           out_data,
  output logic [$clog2(N_OUT)-1:0]   out_class
);

  localparam int unsigned MAXW = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned TW   = $clog2(MAXW + 1);
  localparam int unsigned CLW  = $clog2(N_OUT);
  localparam int unsigned HIW  = $clog2(N_HID);
  localparam int unsigned NREC = N_HID + N_OUT + 2;
  localparam int unsigned RW   = $clog2(NREC);
  localparam int unsigned MAXB = (MAXW + CHUNK - 1) / CHUNK;
  localparam int unsigned BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int unsigned BUFW = MAXB * CHUNK;
  localparam int unsigned B_W1 = (N_IN + CHUNK - 1) / CHUNK;
  localparam int unsigned B_W2 = (N_HID + CHUNK - 1) / CHUNK;
  localparam int unsigned B_T  = (TW + CHUNK - 1) / CHUNK;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t              state;
  logic [RW-1:0]       rec;
  logic [BW-1:0]       beat;
  logic [BUFW-1:0]     buf_q;
  logic [N_IN-1:0]     w1 [N_HID];
  logic [N_HID-1:0]    w2 [N_OUT];
  logic [TW-1:0]       t1, t2;
  logic                v1, v2;

  logic [BUFW-1:0]     word_c;
  logic [BW-1:0]       last_beat_c;
  logic [HIW-1:0]      w1_idx_c;
  logic [CLW-1:0]      w2_idx_c;
  logic                adv2_c, acc1_c, pipe_empty_c;
  logic [TW-1:0]       pop1 [N_HID];
  logic [TW-1:0]       pop2 [N_OUT];
  logic [TW-1:0]       best_c;
  logic [N_HID-1:0]    hid_c;
  logic [N_OUT-1:0]    out_c;
  logic [CLW-1:0]      cls_c;

  assign pipe_empty_c = !v1 && !v2;
  assign adv2_c       = v1 && (!v2 || out_ready);
  assign in_ready     = !reset && ena && (state == IDLE) && (!v1 || adv2_c);
  assign acc1_c       = in_valid && in_ready;
  assign out_valid    = v2;
  assign load_busy    = (state == LOAD);
  assign w1_idx_c     = HIW'(rec);
  assign w2_idx_c     = CLW'(rec - RW'(N_HID));

  // Current beat merged into the record buffer so the last beat commits the same cycle
  always_comb begin
    word_c = buf_q;
    word_c[int'(beat) * CHUNK +: CHUNK] = load_data;
    if (rec < RW'(N_HID))              last_beat_c = BW'(B_W1 - 1);
    else if (rec < RW'(N_HID + N_OUT)) last_beat_c = BW'(B_W2 - 1);
    else                               last_beat_c = BW'(B_T - 1);
  end

  always_comb begin
    for (int i = 0; i < N_HID; i++) begin
      pop1[i] = '0;
      for (int j = 0; j < N_IN; j++) pop1[i] = pop1[i] + TW'(~(in_data[j] ^ w1[i][j]));
      hid_c[i] = ({1'b0, pop1[i]} >= {1'b0, t1});
    end
  end

  // Layer 2 on the registered hidden vector; argmax on raw popcounts, ties to lowest index
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      pop2[k] = '0;
      for (int j = 0; j < N_HID; j++) pop2[k] = pop2[k] + TW'(~(hid_data[j] ^ w2[k][j]));
      out_c[k] = ({1'b0, pop2[k]} >= {1'b0, t2});
    end
    best_c = pop2[0];
    cls_c  = '0;
    for (int k = 1; k < N_OUT; k++) begin
      if (pop2[k] > best_c) begin
        best_c = pop2[k];
        cls_c  = CLW'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rec       <= '0;
      beat      <= '0;
      buf_q     <= '0;
      load_done <= 1'b0;
      t1        <= TW'(THR_L1);
      t2        <= TW'(THR_L2);
      for (int i = 0; i < N_HID; i++) w1[i] <= '0;
      for (int k = 0; k < N_OUT; k++) w2[k] <= '0;
    end else if (ena) begin
      load_done <= 1'b0;
      if (load_start && pipe_empty_c) begin
        state <= LOAD;
        rec   <= '0;
        beat  <= '0;
      end else if (state == LOAD && load_valid) begin
        buf_q <= word_c;
        if (beat == last_beat_c) begin
          beat <= '0;
          if (rec < RW'(N_HID))              w1[w1_idx_c] <= word_c[N_IN-1:0];
          else if (rec < RW'(N_HID + N_OUT)) w2[w2_idx_c] <= word_c[N_HID-1:0];
          else if (rec == RW'(N_HID + N_OUT)) t1 <= word_c[TW-1:0];
          else                               t2 <= word_c[TW-1:0];
          if (rec == RW'(NREC - 1)) begin
            state     <= IDLE;
            rec       <= '0;
            load_done <= 1'b1;
          end else begin
            rec <= rec + RW'(1);
          end
        end else begin
          beat <= beat + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      hid_data  <= '0;
      out_data  <= '0;
      out_class <= '0;
    end else if (ena) begin
      if (acc1_c) begin
        hid_data <= hid_c;
        v1       <= 1'b1;
      end else if (adv2_c) begin
        v1 <= 1'b0;
      end
      if (adv2_c) begin
        out_data  <= out_c;
        out_class <= cls_c;
        v2        <= 1'b1;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_mlp_pipe.sv
// Scoreboard bench for bnn_mlp_pipe: directed loads and vectors with hand-computed results.
module tb_bnn_mlp_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       load_busy, load_done;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [7:0] hid_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_class;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_out = 0;
  int or_mode = 0;
  int pidx = 0;
  logic [3:0] pat = 4'b1001;
  logic [5:0] exp_q[$];
  logic [3:0] lb [26];

  bnn_mlp_pipe dut (
    .clk(clk), .reset(reset), .ena(ena),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_busy(load_busy), .load_done(load_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hid_data(hid_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_class(out_class)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected results on each output transfer and checks stall behaviour
  initial begin
    logic       hold_pend;
    logic [5:0] held;
    logic [5:0] e;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_data, out_class}), 32'(held));
        hold_pend = 1'b0;
      end
      if (!reset && out_valid && !out_ready) begin
        held = {out_data, out_class};
        hold_pend = 1'b1;
      end
      if (!reset && (n_acc - n_out) == 2 && !out_ready && in_valid)
        chk("in_ready_full", 32'(in_ready), 32'd0);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h required=none", {out_data, out_class});
        end else begin
          e = exp_q.pop_front();
          chk("out_data_class", 32'({out_data, out_class}), 32'(e));
        end
        n_out++;
      end
    end
  end

  task automatic build(input logic [7:0] w1, input logic [31:0] w2,
                       input logic [3:0] t1, input logic [3:0] t2);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      lb[2*i]   = w1[3:0];
      lb[2*i+1] = w1[7:4];
    end
    for (int k = 0; k < 4; k++) begin
      r = w2[8*k +: 8];
      lb[16+2*k] = r[3:0];
      lb[17+2*k] = r[7:4];
    end
    lb[24] = t1;
    lb[25] = t2;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] eh,
                      input logic [3:0] eo, input logic [1:0] ec);
    bit acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 200 && !acc; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      acc = in_ready;
      @(posedge clk);
    end
    if (!acc) tmo("send_accept");
    else begin
      exp_q.push_back({eo, ec});
      n_acc++;
      #1;
      chk("hid_data", 32'(hid_data), 32'(eh));
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      #2;
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) tmo("drain");
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Optional n_pre garbage beats, then a restart (optionally colliding with a beat), then lb[]
  task automatic do_load(input int n_pre, input bit collide);
    @(negedge clk);
    in_valid   = 1'b0;
    load_start = 1'b1;
    if (n_pre > 0) begin
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < n_pre; i++) begin
        load_valid = 1'b1;
        load_data  = 4'hF;
        @(negedge clk);
      end
      load_start = 1'b1;
    end
    load_valid = collide;
    load_data  = 4'hF;
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("load_busy_on", 32'(load_busy), 32'd1);
    chk("in_ready_loading", 32'(in_ready), 32'd0);
    for (int i = 0; i < 26; i++) begin
      load_valid = 1'b1;
      load_data  = lb[i];
      @(negedge clk);
      #1;
      chk("load_done_pulse", 32'(load_done), 32'(i == 25));
    end
    load_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("load_done_clear", 32'(load_done), 32'd0);
    chk("load_busy_off", 32'(load_busy), 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_load_busy", 32'(load_busy), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hid", 32'(hid_data), 32'd0);
    chk("rst_out", 32'({out_data, out_class}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    send(8'h00, 8'hFF, 4'h0, 2'd0);
    send(8'hFF, 8'h00, 4'hF, 2'd0);
    drain();

    build(8'hA5, 32'hFFFF_FFFF, 4'd8, 4'd1);
    do_load(0, 1'b0);
    send(8'hA5, 8'hFF, 4'hF, 2'd0);
    drain();

    or_mode = 1;
    send(8'hA5, 8'hFF, 4'hF, 2'd0);
    send(8'h00, 8'h00, 4'h0, 2'd0);
    send(8'hA5, 8'hFF, 4'hF, 2'd0);
    send(8'hA5, 8'hFF, 4'hF, 2'd0);
    send(8'h3C, 8'h00, 4'h0, 2'd0);
    send(8'hA5, 8'hFF, 4'hF, 2'd0);
    send(8'hFF, 8'h00, 4'h0, 2'd0);
    send(8'hA4, 8'h00, 4'h0, 2'd0);
    send(8'hA5, 8'hFF, 4'hF, 2'd0);
    send(8'h5A, 8'h00, 4'h0, 2'd0);
    drain();
    or_mode = 0;

    or_mode = 2;
    send(8'hA5, 8'hFF, 4'hF, 2'd0);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #1;
      seen = out_valid;
    end
    if (!seen) tmo("wait_out_valid");
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    #1;
    chk("load_start_ignored", 32'(load_busy), 32'd0);
    or_mode = 0;
    drain();

    // W1=0, T1=0 -> hidden all ones; W2 pops 0,4,8,8 -> out 1100, class 2 (tie to lower)
    build(8'h00, 32'hFFFF_0F00, 4'd0, 4'd6);
    do_load(5, 1'b1);
    send(8'h00, 8'hFF, 4'hC, 2'd2);
    send(8'h6B, 8'hFF, 4'hC, 2'd2);
    drain();

    // T1=9 exceeds fan-in -> hidden all zeros; W2 pops 8,4,0,0 -> out 0001, class 0
    build(8'h00, 32'hFFFF_0F00, 4'd9, 4'd6);
    do_load(0, 1'b0);
    send(8'h00, 8'h00, 4'h1, 2'd0);
    send(8'hFF, 8'h00, 4'h1, 2'd0);
    drain();

    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1;
      load_data  = 4'h3;
      @(negedge clk);
    end
    load_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midload_rst_busy", 32'(load_busy), 32'd0);
    chk("midload_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h00, 8'hFF, 4'h0, 2'd0);
    send(8'hFF, 8'h00, 4'hF, 2'd0);
    drain();

    @(negedge clk);
    ena = 1'b0;
    #1;
    chk("ena_low_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    ena = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

endmodule
